// File: rtl/sonic_tx_ctl_66.sv
// SONIC 66b transmit buffer between DMA and gearbox, with status flags and drop counters.
// Optional SONIC_TX_IDLE_INSERT_EN: underflow reads emit an idle control block.
module sonic_tx_ctl_66 #(
   parameter int DEPTH_LOG2      = 9,
   parameter int ALMOST_FULL_TH  = 2**DEPTH_LOG2 - 8,
   parameter int ALMOST_EMPTY_TH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wrena,
   input  logic                  wrreq,
   input  logic [127:0]          data_in,
   input  logic                  rdena,
   input  logic                  rdreq,
   output logic [65:0]           data_out,
   output logic                  data_valid,
   output logic [DEPTH_LOG2:0]   tx_ring_rptr,
   output logic [DEPTH_LOG2:0]   usedw,
   output logic                  full,
   output logic                  almost_full,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [15:0]           overflow_cnt,
   output logic [15:0]           underflow_cnt
);

   localparam int AW = DEPTH_LOG2;

   typedef logic [AW:0] ptr_t;

   localparam ptr_t DEPTH  = {1'b1, {AW{1'b0}}};
   localparam ptr_t AF_TH  = ptr_t'(ALMOST_FULL_TH);
   localparam ptr_t AE_TH  = ptr_t'(ALMOST_EMPTY_TH);
   localparam ptr_t ONE    = ptr_t'(1);

`ifdef SONIC_TX_IDLE_INSERT_EN
   localparam logic [65:0] IDLE_BLK = 66'h7A;
`endif

   ptr_t        wptr;
   ptr_t        rptr;
   logic [65:0] mem [2**AW];

   logic wr_req;
   logic rd_req;
   logic wr_ok;
   logic rd_ok;
   logic ovf;
   logic udf;
   logic unused_hi;

   assign unused_hi = ^data_in[127:66];

   assign usedw        = wptr - rptr;
   assign full         = (usedw == DEPTH);
   assign empty        = (usedw == '0);
   assign almost_full  = (usedw >= AF_TH);
   assign almost_empty = (usedw <= AE_TH);
   assign tx_ring_rptr = rptr;

   assign wr_req = wrena & wrreq;
   assign rd_req = rdena & rdreq;
   assign wr_ok  = wr_req & ~full;
   assign rd_ok  = rd_req & ~empty;
   assign ovf    = wr_req & full;
   assign udf    = rd_req & empty;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (wr_ok) mem[wptr[AW-1:0]] <= data_in[65:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr          <= '0;
         rptr          <= '0;
         data_out      <= '0;
         data_valid    <= 1'b0;
         overflow_cnt  <= '0;
         underflow_cnt <= '0;
      end else begin
         data_valid <= rd_ok;
         if (wr_ok) wptr <= wptr + ONE;
         if (rd_ok) begin
            rptr     <= rptr + ONE;
            data_out <= mem[rptr[AW-1:0]];
         end
`ifdef SONIC_TX_IDLE_INSERT_EN
         if (udf) begin
            data_out   <= IDLE_BLK;
            data_valid <= 1'b1;
         end
`endif
         if (ovf && overflow_cnt != 16'hFFFF)
            overflow_cnt <= overflow_cnt + 16'd1;
         if (udf && underflow_cnt != 16'hFFFF)
            underflow_cnt <= underflow_cnt + 16'd1;
      end
   end

endmodule

// File: doc/sonic_tx_ctl_66.md
SONIC_TX_CTL_66 -- requirements
Module: sonic_tx_ctl_66

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 9, giving a buffer depth of 2^DEPTH_LOG2 66-bit blocks.
REQ-002 SHALL have parameter ALMOST_FULL_TH, default 2^DEPTH_LOG2-8, giving the usedw level at or above which almost_full asserts.
REQ-003 SHALL have parameter ALMOST_EMPTY_TH, default 8, giving the usedw level at or below which almost_empty asserts.
REQ-004 SHALL have these ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- wrena  in  1  write enable (enable_sfp, xcvr_ready).
- wrreq  in  1  DMA write strobe.
- data_in  in  128  DMA word; block in [65:0], [127:66] ignored.
- rdena  in  1  read enable (enable_sfp, xcvr_ready).
- rdreq  in  1  gearbox requests one block.
- data_out  out  66  {payload[63:0], sync[1:0]} toward the gearbox.
- data_valid  out  1  data_out was produced this cycle.
- tx_ring_rptr  out  DEPTH_LOG2+1  read pointer exported to the irq logic.
- usedw  out  DEPTH_LOG2+1  current buffer occupancy.
- full, almost_full, empty, almost_empty  out  1 each  status flags.
- overflow_cnt  out  16  count of dropped writes.
- underflow_cnt  out  16  count of reads made while empty.

Function
REQ-005 SHALL accept a write when wrena && wrreq && !full, storing data_in[65:0] at wptr[DEPTH_LOG2-1:0] and incrementing wptr.
REQ-006 SHALL accept a read when rdena && rdreq && !empty: the block at rptr appears on data_out with data_valid=1 on the next cycle (1-cycle latency), and rptr increments.
REQ-007 Pointers SHALL be DEPTH_LOG2+1 bits wide and wrap modulo 2^(DEPTH_LOG2+1), with usedw = wptr - rptr.
REQ-008 SHALL set full when usedw == 2^DEPTH_LOG2 and empty when usedw == 0, with all flags derived from registered pointers.
REQ-009 On a simultaneous accepted read and write, usedw SHALL be unchanged.
REQ-010 A write while full SHALL be dropped even if a read occurs the same cycle, and overflow_cnt SHALL increment.
REQ-011 A read while empty SHALL not be bypassed from a same-cycle write, and underflow_cnt SHALL increment.
REQ-012 Both counters SHALL saturate at 16'hFFFF.
REQ-013 When rdena=0 or rdreq=0, data_valid SHALL be 0 the next cycle and data_out SHALL hold its value.
REQ-014 tx_ring_rptr SHALL equal rptr, registered.

Reset
REQ-015 While reset=1 at a clock edge, the block SHALL clear wptr, rptr, usedw, data_out, data_valid and both counters, and set empty=1, almost_empty=1, full=0, almost_full=0.
REQ-016 Reset asserted mid-operation SHALL discard all buffered blocks, and no data_valid SHALL appear in the cycle after reset.
REQ-017 Memory contents SHALL not be cleared by reset.

Configuration
REQ-018 With macro SONIC_TX_IDLE_INSERT_EN defined, an underflow read (REQ-011) SHALL drive data_out=66'h7A (sync 2'b10, block type 8'h1E, idles zero) with data_valid=1 on the next cycle.
REQ-019 Without SONIC_TX_IDLE_INSERT_EN, an underflow read SHALL leave data_out held and data_valid=0.
REQ-020 The underflow counter SHALL increment in both builds.

Verification
REQ-021 Reset, then write 3 blocks 66'h1..66'h3, then hold rdreq=1 for 4 cycles -> data_out 1,2,3 in order with data_valid=1, one cycle after each read; usedw returns to 0; empty=1.
REQ-022 Fill 2^DEPTH_LOG2 blocks, then write once more -> full=1, usedw=512, overflow_cnt=1, and the extra block is never read out.
REQ-023 With 1 block buffered, read and write in the same cycle -> usedw stays at 1 and the data stays in order across the pointer wrap after 1100 cycles of streaming.
REQ-024 Read while empty -> underflow_cnt=1; data_out=66'h7A with data_valid=1 if SONIC_TX_IDLE_INSERT_EN is defined, else data_valid=0.
REQ-025 Assert reset with 100 blocks buffered -> usedw=0, counters=0, tx_ring_rptr=0, and a subsequent read underflows.
REQ-026 Hold wrena=0 with wrreq=1 -> no writes accepted, usedw=0, and overflow_cnt unchanged.
